// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling shuffle: walks i over S, accumulates j and swaps S[i]/S[j].
// Optional debug observation ports are enabled with `define KSA_SHUFFLE_DEBUG_EN.
module ksa_shuffle #(
  parameter int M       = 8,
  parameter int KEY_LEN = 3,
  parameter int KEY_W   = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [KEY_W-1:0] secret_key,
  output logic [M-1:0]     shuffle_address,
  output logic [M-1:0]     shuffle_data,
  output logic             shuffle_wren,
  input  logic [M-1:0]     shuffle_q,
  output logic             busy,
  output logic             finish
`ifdef KSA_SHUFFLE_DEBUG_EN
  ,
  output logic [M-1:0]     dbg_i,
  output logic [M-1:0]     dbg_j,
  output logic [M:0]       dbg_swaps
`endif
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_I   = 4'd1,
    WT_I   = 4'd2,
    CALC_J = 4'd3,
    RD_J   = 4'd4,
    WT_J   = 4'd5,
    WR_I   = 4'd6,
    WR_J   = 4'd7,
    NEXT   = 4'd8,
    DONE   = 4'd9
  } state_t;

  state_t          state_r;
  logic [M-1:0]    i_r;
  logic [M-1:0]    j_r;
  logic [M-1:0]    si_r;
  logic [M-1:0]    addr_r;
  logic [M-1:0]    data_r;
  logic [KW-1:0]   k_r;
  logic            wren_r;
  logic            busy_r;
  logic            finish_r;
  logic [M-1:0]    key_byte_s;
  logic [M-1:0]    j_next_s;

  // Key byte selection (byte 0 is the most significant) and next j
  always_comb begin
    key_byte_s = '0;
    for (int b = 0; b < KEY_LEN; b++) begin
      if (k_r == KW'(b)) begin
        key_byte_s = M'(secret_key[KEY_W-1-8*b -: 8]);
      end else begin
        key_byte_s = key_byte_s;
      end
    end
    j_next_s = j_r + shuffle_q + key_byte_s;
  end

  // Shuffle FSM; outputs are registered with the value belonging to the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      i_r      <= '0;
      j_r      <= '0;
      si_r     <= '0;
      k_r      <= '0;
      addr_r   <= '0;
      data_r   <= '0;
      wren_r   <= 1'b0;
      busy_r   <= 1'b0;
      finish_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RD_I;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            addr_r  <= '0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_I:   state_r <= WT_I;
        WT_I:   state_r <= CALC_J;
        CALC_J: begin
          si_r    <= shuffle_q;
          j_r     <= j_next_s;
          addr_r  <= j_next_s;
          state_r <= RD_J;
        end
        RD_J:   state_r <= WT_J;
        WT_J: begin
          addr_r  <= i_r;
          wren_r  <= 1'b1;
          state_r <= WR_I;
        end
        WR_I: begin
          addr_r  <= j_r;
          data_r  <= si_r;
          state_r <= WR_J;
        end
        WR_J: begin
          wren_r  <= 1'b0;
          state_r <= NEXT;
        end
        NEXT: begin
          if (i_r == {M{1'b1}}) begin
            busy_r   <= 1'b0;
            finish_r <= 1'b1;
            state_r  <= DONE;
          end else begin
            i_r     <= i_r + M'(1);
            addr_r  <= i_r + M'(1);
            k_r     <= (k_r == KW'(KEY_LEN - 1)) ? '0 : k_r + KW'(1);
            state_r <= RD_I;
          end
        end
        DONE: begin
          // No automatic rerun: the sequencer must drop start before the next pass
          if (!start) begin
            finish_r <= 1'b0;
            addr_r   <= '0;
            data_r   <= '0;
            state_r  <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          wren_r   <= 1'b0;
          busy_r   <= 1'b0;
          finish_r <= 1'b0;
        end
      endcase
    end
  end

  // S[j] is forwarded straight from the RAM read port during the first write
  assign shuffle_data    = (state_r == WR_I) ? shuffle_q : data_r;
  assign shuffle_address = addr_r;
  assign shuffle_wren    = wren_r;
  assign busy            = busy_r;
  assign finish          = finish_r;

`ifdef KSA_SHUFFLE_DEBUG_EN
  logic [M:0] swaps_r;

  // Count completed swaps of the current pass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swaps_r <= '0;
    end else if (state_r == IDLE && start) begin
      swaps_r <= '0;
    end else if (state_r == WR_J) begin
      swaps_r <= swaps_r + (M+1)'(1);
    end else begin
      swaps_r <= swaps_r;
    end
  end

  assign dbg_i     = i_r;
  assign dbg_j     = j_r;
  assign dbg_swaps = swaps_r;
`endif

endmodule
